// File: rtl/fetch_queue_stage.sv
// Instruction fetch: owns the PC, buffers {pc, instr} pairs in a DEPTH-entry queue for decode.
// Latency: a word fetched in cycle N is at the queue head in cycle N+1 when the queue was empty.
// Backpressure: instr_ready low fills the queue, then the PC holds; redirect squashes everything.
module fetch_queue_stage #(
  parameter int         DEPTH    = 2,
  parameter logic [7:0] PC_STEP  = 8'd1,
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  output logic [7:0]  imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        redirect,
  input  logic [7:0]  redirect_target,
  output logic [15:0] instr,
  output logic [7:0]  instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] fetch_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(DEPTH - 1);

  logic [7:0]       pc_q, pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [15:0]      fetch_count_q, fetch_count_d;
  logic [7:0]       mem_pc_q    [DEPTH];
  logic [7:0]       mem_pc_d    [DEPTH];
  logic [15:0]      mem_instr_q [DEPTH];
  logic [15:0]      mem_instr_d [DEPTH];

  logic deq;
  logic can_enq;
  logic enq;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + PTR_W'(1);
  endfunction

  // Head presentation: a redirect hides the head so nothing stale is consumed.
  always_comb begin
    instr_valid = (count_q != '0) & ~redirect;
    instr       = instr_valid ? mem_instr_q[rd_ptr_q] : 16'h0000;
    instr_pc    = instr_valid ? mem_pc_q[rd_ptr_q]    : 8'h00;
    imem_addr   = pc_q;
    fetch_count = fetch_count_q;
  end

  // Queue/PC next state; redirect overrides enqueue, dequeue and pointer motion.
  always_comb begin
    deq     = instr_valid & instr_ready;
    can_enq = (count_q < DEPTH_C) | deq;
    enq     = can_enq & ~redirect;

    pc_d          = pc_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    fetch_count_d = fetch_count_q;
    mem_pc_d      = mem_pc_q;
    mem_instr_d   = mem_instr_q;

    if (redirect) begin
      pc_d     = redirect_target;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (enq) begin
        mem_pc_d[wr_ptr_q]    = pc_q;
        mem_instr_d[wr_ptr_q] = imem_rdata;
        wr_ptr_d              = ptr_inc(wr_ptr_q);
        pc_d                  = pc_q + PC_STEP;
        if (fetch_count_q != 16'hFFFF) begin
          fetch_count_d = fetch_count_q + 16'd1;
        end
      end
      if (deq) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      unique case ({enq, deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; reset empties the queue immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      fetch_count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc_q[i]    <= '0;
        mem_instr_q[i] <= '0;
      end
    end else begin
      pc_q          <= pc_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      fetch_count_q <= fetch_count_d;
      mem_pc_q      <= mem_pc_d;
      mem_instr_q   <= mem_instr_d;
    end
  end

endmodule
